// File: rtl/data_memory_pkg.sv
// Shared state type and boot-table constants for the data memory controller.
package data_memory_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    localparam int DMEM_INIT_LEN = 4;

    localparam logic [31:0] DMEM_INIT_VALS [DMEM_INIT_LEN] = '{32'd1, 32'd22, 32'd5, 32'd0};

    // Words beyond the table boot to zero; callers resize to their own word width.
    function automatic logic [31:0] DMEM_INIT_WORD(input logic [31:0] idx);
        if (idx < 32'(DMEM_INIT_LEN)) begin
            return DMEM_INIT_VALS[idx[1:0]];
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// DEPTH x DATA_W storage: synchronous single-port write, asynchronous read, no reset.
module data_memory_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked word-addressed data memory with valid/ready requests and registered responses.
// Build option DATA_MEMORY_CTRL_INIT_EN adds the reset-time boot-table init sequencer.
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              addr_err,
    output logic              init_busy
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic              inRange;
    logic              accept;
    logic [IDX_W-1:0]  reqIdx;
    logic              arrWe;
    logic [IDX_W-1:0]  arrWaddr;
    logic [DATA_W-1:0] arrWdata;
    logic [DATA_W-1:0] arrRdata;

    logic              rspValid_q;
    logic              addrErr_q;
    logic [DATA_W-1:0] rspData_q;
    logic [DATA_W-1:0] rspData_d;

    // Index bits are only taken once the full address has passed the range check.
    assign inRange = {1'b0, req_addr} < DEPTH_EXT;
    assign reqIdx  = inRange ? req_addr[IDX_W-1:0] : '0;
    assign accept  = req_valid & req_ready;

`ifdef DATA_MEMORY_CTRL_INIT_EN
    dmem_state_e      state_q, state_d;
    logic [IDX_W-1:0] initCnt_q, initCnt_d;
    logic             initWe;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= INIT;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        initWe    = 1'b0;
        if (state_q == INIT) begin
            initWe    = 1'b1;
            initCnt_d = initCnt_q + IDX_W'(1);
            if (initCnt_q == IDX_W'(DEPTH - 1)) begin
                state_d   = RUN;
                initCnt_d = '0;
            end
        end
    end

    assign req_ready = (state_q == RUN) & ~clr;
    assign init_busy = (state_q == INIT) | clr;
    assign arrWe     = ~clr & (initWe | (accept & req_we & inRange));
    assign arrWaddr  = initWe ? initCnt_q : reqIdx;
    assign arrWdata  = initWe ? DATA_W'(DMEM_INIT_WORD(32'(initCnt_q))) : req_wdata;
`else
    logic run_q;

    // One dead cycle after clr keeps the handshake quiet while reset releases.
    always_ff @(posedge clk) begin
        if (clr) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign req_ready = run_q & ~clr;
    assign init_busy = 1'b0;
    assign arrWe     = ~clr & accept & req_we & inRange;
    assign arrWaddr  = reqIdx;
    assign arrWdata  = req_wdata;
`endif

    data_memory_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arrWe),
        .waddr (arrWaddr),
        .wdata (arrWdata),
        .raddr (reqIdx),
        .rdata (arrRdata)
    );

    always_comb begin
        rspData_d = '0;
        if (inRange) begin
            rspData_d = req_we ? req_wdata : arrRdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rspValid_q <= 1'b0;
            addrErr_q  <= 1'b0;
            rspData_q  <= '0;
        end else begin
            rspValid_q <= accept;
            if (accept) begin
                addrErr_q <= ~inRange;
                rspData_q <= rspData_d;
            end
        end
    end

    // clr discards any response that is already on the way out.
    assign rsp_valid = rspValid_q & ~clr;
    assign rsp_data  = clr ? '0 : rspData_q;
    assign addr_err  = addrErr_q & ~clr;

endmodule
